// File: rtl/alu_slice_sequencer.sv
// Multi-cycle sequencer driving a narrow ripple ALU slice, LSB slice first, chaining carry per beat.
// Optional build macro ALU_SEQ_ZERO_FLAG_EN adds a registered RspZero output.
module alu_slice_sequencer #(
   parameter int Width      = 32,
   parameter int SliceWidth = 8
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic [2:0]            ReqOp,
   input  logic [Width-1:0]      ReqA,
   input  logic [Width-1:0]      ReqB,
   output logic [SliceWidth-1:0] SliceA,
   output logic [SliceWidth-1:0] SliceB,
   output logic                  SliceCarryIn,
   output logic                  SliceOr,
   output logic                  SliceFloodCarry,
   output logic                  SliceInvertA,
   output logic                  SliceInvertB,
   input  logic                  SliceCarryOut,
   input  logic [SliceWidth-1:0] SliceOut,
   output logic                  RspValid,
   input  logic                  RspReady,
   output logic [Width-1:0]      RspData,
   output logic                  RspCarry
`ifdef ALU_SEQ_ZERO_FLAG_EN
   ,
   output logic                  RspZero
`endif
);

   localparam int Beats = Width / SliceWidth;
   localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SLT  = 3'd5;
   localparam logic [2:0] OP_SLTU = 3'd6;
   localparam logic [2:0] OP_NAND = 3'd7;

   generate
      if ((Width % SliceWidth) != 0) begin : g_bad_width
         $error("alu_slice_sequencer: Width must be a multiple of SliceWidth");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [BeatW-1:0] beat_r;
   logic [Width-1:0] a_r;
   logic [Width-1:0] b_r;
   logic [2:0]       op_r;
   logic [Width-1:0] result_r;
   logic             carry_r;
   logic [Width-1:0] rsp_data_r;
   logic             rsp_carry_r;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic             rsp_zero_r;
`endif

   logic             inv_a_s;
   logic             inv_b_s;
   logic             or_s;
   logic             flood_s;
   logic             is_sub_s;
   logic             is_arith_s;
   logic             slt_bit_s;
   logic [Width-1:0] assembled_s;
   logic [Width-1:0] final_s;

   // State register
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ReqValid) state_s = ST_RUN;
            else          state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (beat_r == LastBeat) state_s = ST_DONE;
            else                    state_s = ST_RUN;
         end
         ST_DONE: begin
            if (RspReady) state_s = ST_IDLE;
            else          state_s = ST_DONE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Per-op ALU control lines
   always_comb begin
      inv_a_s = 1'b0;
      inv_b_s = 1'b0;
      or_s    = 1'b0;
      flood_s = 1'b0;
      case (op_r)
         OP_ADD:  begin inv_a_s = 1'b0; inv_b_s = 1'b0; or_s = 1'b0; flood_s = 1'b0; end
         OP_SUB,
         OP_SLT,
         OP_SLTU: begin inv_a_s = 1'b0; inv_b_s = 1'b1; or_s = 1'b0; flood_s = 1'b0; end
         OP_AND:  begin inv_a_s = 1'b1; inv_b_s = 1'b1; or_s = 1'b1; flood_s = 1'b1; end
         OP_NAND: begin inv_a_s = 1'b1; inv_b_s = 1'b1; or_s = 1'b1; flood_s = 1'b0; end
         OP_OR:   begin inv_a_s = 1'b0; inv_b_s = 1'b0; or_s = 1'b1; flood_s = 1'b0; end
         OP_XOR:  begin inv_a_s = 1'b0; inv_b_s = 1'b1; or_s = 1'b0; flood_s = 1'b1; end
         default: begin inv_a_s = 1'b0; inv_b_s = 1'b0; or_s = 1'b0; flood_s = 1'b0; end
      endcase
      is_sub_s   = (op_r == OP_SUB) || (op_r == OP_SLT) || (op_r == OP_SLTU);
      is_arith_s = is_sub_s || (op_r == OP_ADD);
   end

   // Slice drive: active only while running, otherwise all zero
   always_comb begin
      SliceA          = {SliceWidth{1'b0}};
      SliceB          = {SliceWidth{1'b0}};
      SliceCarryIn    = 1'b0;
      SliceOr         = 1'b0;
      SliceFloodCarry = 1'b0;
      SliceInvertA    = 1'b0;
      SliceInvertB    = 1'b0;
      if (state_r == ST_RUN) begin
         SliceA          = a_r[beat_r * SliceWidth +: SliceWidth];
         SliceB          = b_r[beat_r * SliceWidth +: SliceWidth];
         SliceOr         = or_s;
         SliceFloodCarry = flood_s;
         SliceInvertA    = inv_a_s;
         SliceInvertB    = inv_b_s;
         if (beat_r == {BeatW{1'b0}}) SliceCarryIn = is_sub_s;
         else                         SliceCarryIn = is_arith_s & carry_r;
      end else begin
         SliceCarryIn = 1'b0;
      end
   end

   // Final result: last slice comes straight from the ALU; compares collapse to one bit
   always_comb begin
      assembled_s = result_r;
      assembled_s[(Beats - 1) * SliceWidth +: SliceWidth] = SliceOut;
      slt_bit_s = (a_r[Width-1] ^ b_r[Width-1]) ? a_r[Width-1] : ~SliceCarryOut;
      case (op_r)
         OP_SLT:  final_s = {{(Width-1){1'b0}}, slt_bit_s};
         OP_SLTU: final_s = {{(Width-1){1'b0}}, ~SliceCarryOut};
         default: final_s = assembled_s;
      endcase
   end

   // Operand capture, per-beat accumulation and response registers
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         beat_r      <= {BeatW{1'b0}};
         a_r         <= {Width{1'b0}};
         b_r         <= {Width{1'b0}};
         op_r        <= 3'd0;
         result_r    <= {Width{1'b0}};
         carry_r     <= 1'b0;
         rsp_data_r  <= {Width{1'b0}};
         rsp_carry_r <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         rsp_zero_r  <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ReqValid) begin
                  a_r      <= ReqA;
                  b_r      <= ReqB;
                  op_r     <= ReqOp;
                  beat_r   <= {BeatW{1'b0}};
                  result_r <= {Width{1'b0}};
                  carry_r  <= 1'b0;
               end
            end
            ST_RUN: begin
               result_r[beat_r * SliceWidth +: SliceWidth] <= SliceOut;
               carry_r <= SliceCarryOut;
               beat_r  <= beat_r + BeatW'(1);
               if (beat_r == LastBeat) begin
                  rsp_data_r  <= final_s;
                  rsp_carry_r <= is_arith_s & SliceCarryOut;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                  rsp_zero_r  <= (final_s == {Width{1'b0}});
`endif
               end
            end
            default: begin
               carry_r <= carry_r;
            end
         endcase
      end
   end

   assign ReqReady = (state_r == ST_IDLE);
   assign RspValid = (state_r == ST_DONE);
   assign RspData  = rsp_data_r;
   assign RspCarry = rsp_carry_r;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   assign RspZero  = rsp_zero_r;
`endif

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Scoreboard bench for alu_slice_sequencer with a behavioural 8-bit ALU slice attached.
module tb_alu_slice_sequencer;

   localparam int W  = 32;
   localparam int SW = 8;

   logic          Clock = 1'b0;
   logic          ResetN = 1'b0;
   logic          ReqValid = 1'b0;
   logic          ReqReady;
   logic [2:0]    ReqOp = 3'd0;
   logic [W-1:0]  ReqA = '0;
   logic [W-1:0]  ReqB = '0;
   logic [SW-1:0] SliceA, SliceB;
   logic          SliceCarryIn, SliceOr, SliceFloodCarry, SliceInvertA, SliceInvertB;
   logic          SliceCarryOut;
   logic [SW-1:0] SliceOut;
   logic          RspValid;
   logic          RspReady = 1'b0;
   logic [W-1:0]  RspData;
   logic          RspCarry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic          RspZero;
`endif

   alu_slice_sequencer #(.Width(W), .SliceWidth(SW)) dut (
      .Clock(Clock), .ResetN(ResetN),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
      .SliceA(SliceA), .SliceB(SliceB), .SliceCarryIn(SliceCarryIn), .SliceOr(SliceOr),
      .SliceFloodCarry(SliceFloodCarry), .SliceInvertA(SliceInvertA), .SliceInvertB(SliceInvertB),
      .SliceCarryOut(SliceCarryOut), .SliceOut(SliceOut),
      .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspCarry(RspCarry)
`ifdef ALU_SEQ_ZERO_FLAG_EN
      , .RspZero(RspZero)
`endif
   );

   always #5 Clock = ~Clock;

   // Behavioural ripple ALU slice: invert, then OR or add; flood carry forces every carry to 1
   logic [SW-1:0] alu_a, alu_b;
   logic [SW:0]   alu_sum;
   always_comb begin
      alu_a   = SliceInvertA ? ~SliceA : SliceA;
      alu_b   = SliceInvertB ? ~SliceB : SliceB;
      alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{SW{1'b0}}, SliceCarryIn};
      if (SliceOr) begin
         SliceOut      = (alu_a | alu_b) ^ {SW{SliceFloodCarry}};
         SliceCarryOut = 1'b1;
      end else if (SliceFloodCarry) begin
         SliceOut      = alu_a ^ alu_b ^ {SW{1'b1}};
         SliceCarryOut = 1'b1;
      end else begin
         SliceOut      = alu_sum[SW-1:0];
         SliceCarryOut = alu_sum[SW];
      end
   end

   typedef struct packed {
      logic [W-1:0] data;
      logic         carry;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic cin_trace [0:3];

   function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s, d;
      s = {1'b0, a} + {1'b0, b};
      d = {1'b0, a} + {1'b0, ~b} + 33'd1;
      case (op)
         3'd0: return s;
         3'd1: return d;
         3'd2: return {1'b0, a & b};
         3'd3: return {1'b0, a | b};
         3'd4: return {1'b0, a ^ b};
         3'd5: return {d[W], 31'd0, (a[W-1] ^ b[W-1]) ? a[W-1] : ~d[W]};
         3'd6: return {d[W], 31'd0, ~d[W]};
         default: return {1'b0, ~(a & b)};
      endcase
   endfunction

   task automatic push(input logic [W-1:0] data, input logic carry);
      exp_t e;
      e.data  = data;
      e.carry = carry;
      exp_q.push_back(e);
   endtask

   // Returns at the falling edge right after the accepting edge (beat 0 visible)
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      @(negedge Clock);
      while (!ReqReady && n < 20) begin
         @(negedge Clock);
         n++;
      end
      vectors++;
      if (ReqReady !== 1'b1) begin
         miscompares++;
         $display("FAIL req_ready_wait got %b want 1", ReqReady);
      end
      ReqValid = 1'b1; ReqOp = op; ReqA = a; ReqB = b;
      @(negedge Clock);
      ReqValid = 1'b0;
   endtask

   task automatic collect(input string name, input bit ack);
      int   cyc = 0;
      exp_t e;
      while (!RspValid && cyc < 20) begin
         if (cyc < 4) cin_trace[cyc] = SliceCarryIn;
         @(negedge Clock);
         cyc++;
      end
      vectors++;
      if (cyc != 4) begin
         miscompares++;
         $display("FAIL %s latency got %0d want 4", name, cyc);
      end
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s scoreboard empty got 0 entries want 1", name);
      end else begin
         e = exp_q.pop_front();
         if (RspData !== e.data) begin
            miscompares++;
            $display("FAIL %s data got %h want %h", name, RspData, e.data);
         end
         vectors++;
         if (RspCarry !== e.carry) begin
            miscompares++;
            $display("FAIL %s carry got %b want %b", name, RspCarry, e.carry);
         end
`ifdef ALU_SEQ_ZERO_FLAG_EN
         vectors++;
         if (RspZero !== (e.data == '0)) begin
            miscompares++;
            $display("FAIL %s zero got %b want %b", name, RspZero, (e.data == '0));
         end
`endif
      end
      if (ack) begin
         RspReady = 1'b1;
         @(negedge Clock);
         RspReady = 1'b0;
         vectors++;
         if ({RspValid, ReqReady} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s ack got valid/ready %b want 01", name, {RspValid, ReqReady});
         end
      end
   endtask

   task automatic check_outputs_zero(input string name);
      vectors++;
      if ({SliceA, SliceB, SliceCarryIn, SliceOr, SliceFloodCarry, SliceInvertA, SliceInvertB} !== '0) begin
         miscompares++;
         $display("FAIL %s slice_outputs got %h/%h ctl %b want all 0", name, SliceA, SliceB,
                  {SliceCarryIn, SliceOr, SliceFloodCarry, SliceInvertA, SliceInvertB});
      end
      vectors++;
      if ({RspValid, RspData, RspCarry, ReqReady} !== {1'b0, 32'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL %s rsp got valid %b data %h carry %b ready %b want 0 0 0 1", name,
                  RspValid, RspData, RspCarry, ReqReady);
      end
`ifdef ALU_SEQ_ZERO_FLAG_EN
      vectors++;
      if (RspZero !== 1'b0) begin
         miscompares++;
         $display("FAIL %s reset zero got %b want 0", name, RspZero);
      end
`endif
   endtask

   task automatic test_reset();
      ResetN = 1'b0;
      repeat (3) @(negedge Clock);
      check_outputs_zero("reset");
      ResetN = 1'b1;
   endtask

   task automatic test_add();
      push(32'h0000_0100, 1'b0);
      send(3'd0, 32'h0000_00FF, 32'h0000_0001);
      collect("add_ff_1", 1'b1);
      vectors++;
      if ({cin_trace[0], cin_trace[1]} !== 2'b01) begin
         miscompares++;
         $display("FAIL add_carry_chain got cin beat0/1 %b want 01", {cin_trace[0], cin_trace[1]});
      end
   endtask

   task automatic test_sub_slt();
      push(32'hFFFF_FFFF, 1'b0); send(3'd1, 32'h0, 32'h1);                 collect("sub_0_1", 1'b1);
      vectors++;
      if (cin_trace[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL sub_cin0 got %b want 1", cin_trace[0]);
      end
      push(32'h1, 1'b0);         send(3'd6, 32'h0, 32'h1);                 collect("sltu_0_1", 1'b1);
      push(32'h1, 1'b1);         send(3'd5, 32'hFFFF_FFFF, 32'h1);         collect("slt_m1_1", 1'b1);
      push(32'h0, 1'b0);         send(3'd5, 32'h1, 32'hFFFF_FFFF);         collect("slt_1_m1", 1'b1);
   endtask

   task automatic test_logic();
      push(32'hF000_A500, 1'b0); send(3'd2, 32'hF0F0_A5A5, 32'hFF00_FF00); collect("and", 1'b1);
      push(32'hFFF0_FFA5, 1'b0); send(3'd3, 32'hF0F0_A5A5, 32'hFF00_FF00); collect("or", 1'b1);
      push(32'h0FF0_5AA5, 1'b0); send(3'd4, 32'hF0F0_A5A5, 32'hFF00_FF00); collect("xor", 1'b1);
      push(32'h0FFF_5AFF, 1'b0); send(3'd7, 32'hF0F0_A5A5, 32'hFF00_FF00); collect("nand", 1'b1);
   endtask

   task automatic test_backpressure();
      int stray = 0;
      push(32'd12, 1'b0);
      send(3'd0, 32'd5, 32'd7);
      collect("bp_add", 1'b0);
      for (int i = 0; i < 5; i++) begin
         ReqValid = 1'b1; ReqOp = 3'd1; ReqA = 32'hDEAD_BEEF; ReqB = 32'h1;
         @(negedge Clock);
         vectors++;
         if ({RspValid, ReqReady, RspData} !== {1'b1, 1'b0, 32'd12}) begin
            miscompares++;
            $display("FAIL bp_hold got valid %b ready %b data %h want 1 0 0000000c",
                     RspValid, ReqReady, RspData);
         end
      end
      ReqValid = 1'b0;
      RspReady = 1'b1;
      @(negedge Clock);
      RspReady = 1'b0;
      vectors++;
      if ({RspValid, ReqReady} !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_release got valid/ready %b want 01", {RspValid, ReqReady});
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (RspValid !== 1'b0 || ReqReady !== 1'b1) stray++;
      end
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("FAIL bp_no_accept got %0d busy cycles want 0", stray);
      end
   endtask

   task automatic test_reset_midrun();
      int stray = 0;
      send(3'd0, 32'h1122_3344, 32'h0101_0101);
      repeat (2) @(negedge Clock);
      vectors++;
      if (SliceA !== 8'h22) begin
         miscompares++;
         $display("FAIL midrun_beat2 slice_a got %h want 22", SliceA);
      end
      #1 ResetN = 1'b0;
      #1 check_outputs_zero("midrun_reset");
      @(negedge Clock);
      ResetN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (RspValid !== 1'b0 || ReqReady !== 1'b1) stray++;
      end
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("FAIL midrun_abort got %0d busy cycles want 0", stray);
      end
   endtask

`ifdef ALU_SEQ_ZERO_FLAG_EN
   task automatic test_zero_flag();
      push(32'h0, 1'b1); send(3'd1, 32'h1234_5678, 32'h1234_5678); collect("zero_sub_eq", 1'b1);
      push(32'h2, 1'b0); send(3'd0, 32'h1, 32'h1);                 collect("zero_add_1_1", 1'b1);
   endtask
`endif

   task automatic test_back_to_back();
      logic [W:0]   m;
      logic [W-1:0] a, b;
      logic [2:0]   op;
      for (int i = 0; i < 16; i++) begin
         op = 3'(i % 8);
         a  = $urandom;
         b  = (i % 5 == 0) ? a : $urandom;
         m  = model(op, a, b);
         push(m[W-1:0], m[W]);
         send(op, a, b);
         collect("b2b_random", 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_slt();
      test_logic();
      test_backpressure();
      test_reset_midrun();
`ifdef ALU_SEQ_ZERO_FLAG_EN
      test_zero_flag();
`endif
      test_back_to_back();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
